irq_prio_ctrl: RTL and testbench
================================

IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 4, giving the number of interrupt channels (legal range 2..16).
REQ-002 The block SHALL have parameter BASE_CAUSE, default 16, giving the mcause value of channel 0.
REQ-003 The block SHALL have parameter CAUSE_W, default 5, giving the width of the cause output.
REQ-004 The block SHALL have port clk, input, 1 bit, as its single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, as its asynchronous active-low reset.
REQ-006 The block SHALL have port irq_in, input, NUM_IRQ bits, carrying the raw interrupt sources.
REQ-007 The block SHALL have port edge_mode, input, NUM_IRQ bits; 1 selects rising-edge latched and 0 selects level for that channel.
REQ-008 The block SHALL have port irq_en, input, NUM_IRQ bits, as the per-channel enable mask.
REQ-009 The block SHALL have port clr_valid, input, 1 bit, as a pending-clear strobe.
REQ-010 The block SHALL have port clr_idx, input, $clog2(NUM_IRQ) bits, selecting the channel to clear.
REQ-011 The block SHALL have port ack, input, 1 bit, pulsed when the core takes the trap.
REQ-012 The block SHALL have port done, input, 1 bit, pulsed when the core executes mret.
REQ-013 The block SHALL have port irq_req, output, 1 bit, as the interrupt request to the core.
REQ-014 The block SHALL have port irq_cause, output, CAUSE_W bits, equal to BASE_CAUSE plus the winning channel index.
REQ-015 The block SHALL have port pending, output, NUM_IRQ bits, showing the raw pending state (not masked).

Function
REQ-016 An edge channel SHALL set pending[i] the cycle after a rising edge on irq_in[i], detected against a registered previous value.
REQ-017 A level channel SHALL have pending[i] equal to the registered irq_in[i]; clears to level channels SHALL be ignored.
REQ-018 clr_valid SHALL clear pending[clr_idx] of an edge channel on the next edge of clk.
REQ-019 An out-of-range clr_idx SHALL be ignored.
REQ-020 A set and a clear on the same channel in the same cycle SHALL leave the bit set.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-022 In IDLE, when (pending & irq_en) is nonzero, the FSM SHALL latch the lowest-index set channel as the winner and move to REQ; the lowest index is the highest priority.
REQ-023 In REQ, irq_req SHALL be 1 and irq_cause SHALL hold the latched winner; ack SHALL move the FSM to SERVICE.
REQ-024 In REQ, if the winner's pending or irq_en drops before ack, the FSM SHALL return to IDLE with no trap, and irq_req SHALL drop the next cycle.
REQ-025 In REQ, a higher-priority arrival SHALL NOT preempt the latched winner; re-arbitration SHALL occur only in IDLE.
REQ-026 In SERVICE, irq_req SHALL be 0 and irq_cause SHALL be held; done SHALL move the FSM to IDLE.
REQ-027 ack outside REQ and done outside SERVICE SHALL be ignored.
REQ-028 Latency from the irq_in edge to irq_req SHALL be 2 cycles without synchronisation.
REQ-029 After done, a still-pending channel SHALL re-request 1 cycle later (IDLE then REQ).

Reset
REQ-030 While rst_n is 0, the FSM SHALL be IDLE, pending and the previous-value registers SHALL be 0, irq_req SHALL be 0 and irq_cause SHALL be BASE_CAUSE.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately with no residual pending bits.

Configuration
REQ-032 With IRQ_SYNC_EN defined, irq_in SHALL pass through a 2-flop synchroniser per channel before edge and level detection, making the REQ-028 latency 4 cycles.
REQ-033 With IRQ_SYNC_EN undefined, irq_in SHALL be sampled directly and no synchroniser flops SHALL exist.

Structure
REQ-034 A shared package irq_pkg SHALL hold the FSM state enum (IDLE, REQ, SERVICE) and the constants DEFAULT_NUM_IRQ=4 and DEFAULT_BASE_CAUSE=16.
REQ-035 A combinational sub-module irq_prio_enc SHALL implement the lowest-index priority encoder, giving a valid bit and an index.

Verification
REQ-036 The bench SHALL check: edge on irq_in[1] alone with enables all 1 -> irq_req 2 cycles later with irq_cause=17; ack -> irq_req drops; clear of 1 and done -> IDLE with no re-request.
REQ-037 The bench SHALL check: edge on irq_in[0] alone -> irq_cause=16.
REQ-038 The bench SHALL check: edges on channels 0 and 1 in the same cycle -> irq_cause=16; after ack, clear of 0 and done -> irq_req again 1 cycle later with irq_cause=17.
REQ-039 The bench SHALL check: level channel 2 held high, done pulsed without a clear -> irq_req reasserts with irq_cause=18.
REQ-040 The bench SHALL check: in REQ for channel 3, irq_en[3] drops before ack -> irq_req falls next cycle and the FSM returns to IDLE.
REQ-041 The bench SHALL check: clr_valid on channel 1 coincident with a new edge on channel 1 -> pending[1] stays 1; rst_n pulsed in SERVICE -> all outputs at reset values.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt priority controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int DEFAULT_NUM_IRQ    = 4;
  localparam int DEFAULT_BASE_CAUSE = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Walk from the top down so the lowest set index is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt priority controller: edge/level pending capture, fixed priority, IDLE/REQ/SERVICE handshake.
// Define IRQ_SYNC_EN to put a 2-flop synchroniser on every irq_in bit.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ    = DEFAULT_NUM_IRQ,
  parameter int BASE_CAUSE = DEFAULT_BASE_CAUSE,
  parameter int CAUSE_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic [NUM_IRQ-1:0]         edge_mode,
  input  logic [NUM_IRQ-1:0]         irq_en,
  input  logic                       clr_valid,
  input  logic [$clog2(NUM_IRQ)-1:0] clr_idx,
  input  logic                       ack,
  input  logic                       done,
  output logic                       irq_req,
  output logic [CAUSE_W-1:0]         irq_cause,
  output logic [NUM_IRQ-1:0]         pending,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = $clog2(NUM_IRQ);

  // Handshake: irq_req is high exactly while in REQ; a one-cycle ack there
  // takes the trap (REQ->SERVICE), a one-cycle done in SERVICE returns to IDLE.
  // ack outside REQ and done outside SERVICE have no effect.

  logic [NUM_IRQ-1:0] irq_s, prev_q, pending_q, pending_d, rise, clr_hit;
  irq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d, enc_idx;
  logic               enc_valid, win_active, clr_in_range;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise         = irq_s & ~prev_q;
  assign clr_in_range = {{(32 - IDX_W){1'b0}}, clr_idx} < NUM_IRQ;

  // A rising edge beats a coincident clear; level channels just follow the input.
  always_comb begin
    clr_hit   = '0;
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_hit[i] = clr_valid && clr_in_range && (clr_idx == IDX_W'(i));
      if (edge_mode[i]) begin
        if (rise[i])         pending_d[i] = 1'b1;
        else if (clr_hit[i]) pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = irq_s[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= irq_s;
      pending_q <= pending_d;
    end
  end

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .req   (pending_q & irq_en),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign win_active = pending_q[win_q] & irq_en[win_q];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = REQ;
          win_d   = enc_idx;
        end
      end
      REQ: begin
        if (ack)              state_d = SERVICE;
        else if (!win_active) state_d = IDLE;
      end
      SERVICE: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  assign irq_req   = (state_q == REQ);
  assign irq_cause = CAUSE_W'(BASE_CAUSE) + CAUSE_W'(win_q);
  assign pending   = pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: priority, edge/level capture, handshake and reset abort.
module tb_irq_prio_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in, edge_mode, irq_en;
  logic       clr_valid;
  logic [1:0] clr_idx;
  logic       ack, done;
  logic       irq_req;
  logic [4:0] irq_cause;
  logic [3:0] pending;
  logic [1:0] dbg_state;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  irq_prio_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .irq_en    (irq_en),
    .clr_valid (clr_valid),
    .clr_idx   (clr_idx),
    .ack       (ack),
    .done      (done),
    .irq_req   (irq_req),
    .irq_cause (irq_cause),
    .pending   (pending),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic pulse_clr(input logic [1:0] idx);
    clr_valid = 1'b1; clr_idx = idx; tick(); clr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; edge_mode = 4'b1011; irq_en = 4'hF;
    clr_valid = 1'b0; clr_idx = '0; ack = 1'b0; done = 1'b0;
    tick(); tick();
    check("rst_req",     32'(irq_req),   32'd0);
    check("rst_cause",   32'(irq_cause), 32'd16);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_state",   32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Edge on channel 1 alone: pending after 1 cycle, request after 2.
    irq_in = 4'b0010;
    tick();
    check("e1_pending",  32'(pending), 32'b0010);
    check("e1_req_lat1", 32'(irq_req), 32'd0);
    tick();
    check("e1_req",   32'(irq_req),   32'd1);
    check("e1_cause", 32'(irq_cause), 32'd17);
    irq_in = '0;
    pulse_ack();
    check("e1_ack_req",   32'(irq_req),   32'd0);
    check("e1_svc_state", 32'(dbg_state), 32'(SERVICE));
    check("e1_svc_cause", 32'(irq_cause), 32'd17);
    pulse_clr(2'd1);
    check("e1_clr", 32'(pending), 32'd0);
    pulse_done();
    check("e1_done_state", 32'(dbg_state), 32'(IDLE));
    tick();
    check("e1_no_rereq", 32'(irq_req), 32'd0);

    // Edge on channel 0 alone.
    irq_in = 4'b0001;
    tick(); tick();
    check("e0_req",   32'(irq_req),   32'd1);
    check("e0_cause", 32'(irq_cause), 32'd16);
    irq_in = '0;
    pulse_ack(); pulse_clr(2'd0); pulse_done();
    check("e0_idle", 32'(dbg_state), 32'(IDLE));

    // Channels 0 and 1 together: 0 wins, 1 re-requests after done.
    irq_in = 4'b0011;
    tick(); tick();
    check("e01_cause", 32'(irq_cause), 32'd16);
    irq_in = '0;
    pulse_ack();
    pulse_clr(2'd0);
    check("e01_pending", 32'(pending), 32'b0010);
    pulse_done();
    check("e01_idle_req", 32'(irq_req), 32'd0);
    tick();
    check("e01_rereq",       32'(irq_req),   32'd1);
    check("e01_rereq_cause", 32'(irq_cause), 32'd17);
    pulse_ack(); pulse_clr(2'd1); pulse_done();

    // Level channel 2: clear ignored, re-request after done.
    irq_in = 4'b0100;
    tick(); tick();
    check("l2_cause", 32'(irq_cause), 32'd18);
    pulse_ack();
    pulse_clr(2'd2);
    check("l2_clr_ignored", 32'(pending), 32'b0100);
    pulse_done();
    tick();
    check("l2_rereq",       32'(irq_req),   32'd1);
    check("l2_rereq_cause", 32'(irq_cause), 32'd18);
    irq_in = '0;
    tick(); tick();
    check("l2_drop_state", 32'(dbg_state), 32'(IDLE));
    check("l2_drop_req",   32'(irq_req),   32'd0);

    // Channel 3 in REQ: no preemption by channel 0, enable drop withdraws.
    irq_in = 4'b1000;
    tick(); tick();
    check("e3_cause", 32'(irq_cause), 32'd19);
    irq_in = 4'b1001;
    tick();
    check("e3_nopreempt_cause", 32'(irq_cause), 32'd19);
    check("e3_nopreempt_req",   32'(irq_req),   32'd1);
    irq_en = 4'b0111;
    tick();
    check("e3_withdraw_req",   32'(irq_req),   32'd0);
    check("e3_withdraw_state", 32'(dbg_state), 32'(IDLE));
    tick();
    check("e3_rearb_cause", 32'(irq_cause), 32'd16);
    irq_in = '0;
    pulse_ack(); pulse_clr(2'd0); pulse_clr(2'd3); pulse_done();
    irq_en = 4'hF;
    check("e3_pending_clean", 32'(pending), 32'd0);

    // Clear coincident with a new edge on channel 1 keeps the bit.
    irq_in = 4'b0010; clr_valid = 1'b1; clr_idx = 2'd1;
    tick();
    clr_valid = 1'b0;
    check("setclr_pending", 32'(pending), 32'b0010);
    tick();
    pulse_ack();
    check("setclr_svc", 32'(dbg_state), 32'(SERVICE));

    // Asynchronous reset in SERVICE.
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",     32'(irq_req),   32'd0);
    check("arst_cause",   32'(irq_cause), 32'd16);
    check("arst_pending", 32'(pending),   32'd0);
    check("arst_state",   32'(dbg_state), 32'(IDLE));
    irq_in = '0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_req", 32'(irq_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
